global_bram_port_arbiter: RTL and testbench
===========================================

Name: global_bram_port_arbiter

Overview:
- Shares the single global BRAM port between two requesters in the fused-layer path.
  - Read requester: the weight/IFM loader, which fills the fused buffer.
  - Write requester: the layer-2 OFM writeback.
- Arbitration is read-priority. Write starvation is bounded, write bursts are capped, and a one-cycle bubble is inserted on every direction change.
- Sits between the fused control unit and the global BRAM. It drives the BRAM address, enable and write-enable registers, and returns read data with a valid strobe.

Parameters:
- DATA_W, 32, BRAM data width.
- ADDR_W, 32, byte address width. Addresses step by 4.
- RD_LAT, 1, BRAM read latency in cycles, measured from bram_en to rdata valid.
- MAX_WAIT, 8, maximum consecutive cycles a pending write may be refused before it forces a direction change.
- WR_BURST, 4, maximum consecutive write grants while a read is pending.

Ports:
- clk, in, 1, clock. One clock domain: clk.
- reset, in, 1, reset. Asynchronous, active-high.
- rd_req, in, 1, read request. Held with rd_addr until rd_gnt.
- rd_addr, in, ADDR_W, read byte address.
- rd_gnt, out, 1, read accepted this cycle (combinational).
- rd_data, out, DATA_W, read data.
- rd_valid, out, 1, rd_data valid. One pulse per granted read.
- wr_req, in, 1, write request. Held with wr_addr/wr_data until wr_gnt.
- wr_addr, in, ADDR_W, write byte address.
- wr_data, in, DATA_W, write data.
- wr_gnt, out, 1, write accepted this cycle (combinational).
- bram_en, out, 1, BRAM port enable (registered).
- bram_we, out, 1, BRAM write enable (registered).
- bram_addr, out, ADDR_W, BRAM byte address (registered).
- bram_wdata, out, DATA_W, BRAM write data (registered).
- bram_rdata, in, DATA_W, BRAM read data.
- busy, out, 1, high when state != IDLE or any read is in flight.
- err_misalign, out, 1, sticky flag: a granted address had bits [1:0] != 0.

Behaviour:
- Reset values: every output and register is 0, and state = IDLE. A reset mid-operation discards in-flight reads, so no rd_valid pulse follows.
- Handshake: a transfer occurs in any cycle where req && gnt. gnt is never high without its req.
- Registered BRAM stage: in the cycle after a grant, bram_en=1, bram_we=1 for a write or 0 for a read, and bram_addr/bram_wdata take the granted values. With no grant, bram_en=0 and bram_we=0; addr and wdata hold.
- Read return: rd_valid pulses exactly 1+RD_LAT cycles after rd_gnt. rd_data = bram_rdata in that cycle, held until the next pulse. Implemented as a (1+RD_LAT)-deep valid shift register.
- Counters:
  - wait_cnt, width $clog2(MAX_WAIT+1):
    - cleared when wr_gnt=1 or wr_req=0;
    - otherwise increments, saturating at MAX_WAIT.
  - wr_run:
    - increments on each wr_gnt while in WR;
    - cleared whenever state leaves WR.
- Force condition: force_wr = wr_req && wait_cnt >= MAX_WAIT.
- FSM states: IDLE, RD, WR, TURN. TURN holds a 1-bit target field.
  - IDLE:
    - rd_req → rd_gnt=1, go to RD;
    - else wr_req → wr_gnt=1, go to WR;
    - else stay.
  - RD:
    - rd_req && !force_wr → rd_gnt=1, stay;
    - else wr_req → TURN with target WR, no grant;
    - else → IDLE.
  - WR:
    - wr_req && (!rd_req || wr_run < WR_BURST) → wr_gnt=1, stay;
    - else rd_req → TURN with target RD;
    - else → IDLE.
  - TURN: no grants. Next state = target, where that state's rules apply normally.
- Simultaneous rd_req and wr_req in IDLE: the read wins.
- Requests dropping during TURN: the target state is still entered. It then resolves to IDLE or another TURN per its rules.
- err_misalign: set on any grant with addr[1:0] != 0. The transfer still proceeds unmodified. The flag clears only on reset.
- busy is derived combinationally from state and the valid shift register.

Test Plan:
- Reset: assert reset mid-stream → all outputs 0 asynchronously. Release reset, then hold rd_req=0 and wr_req=0 → bram_en stays 0.
- Read-only: rd_req held at cycles 0-2 with addresses 0x100, 0x104, 0x108 →
  - rd_gnt at cycles 0-2;
  - bram_en=1, bram_we=0 at cycles 1-3 with the same addresses;
  - rd_valid at cycles 2-4 with rd_data = bram_rdata.
- Write-only: wr_req at cycle 0 with addr 0x40 and data 0xDEADBEEF →
  - wr_gnt at cycle 0;
  - at cycle 1: bram_en=1, bram_we=1, bram_addr=0x40, bram_wdata=0xDEADBEEF;
  - no rd_valid.
- Starvation and burst cap, with rd_req and wr_req both held continuously from cycle 0:
  - reads granted at cycles 0-7;
  - cycle 8: force_wr, no grant, enter TURN;
  - cycle 9: TURN;
  - writes granted at cycles 10-13;
  - cycle 14: wr_run=4, go to TURN;
  - read granted at cycle 16.
- Misalign: a granted read at 0x102 → bram_addr=0x102 and err_misalign=1 from cycle 1. The flag stays 1 after later aligned traffic until reset.
- Reset with a read in flight: rd_gnt at cycle 0, reset asserted at cycle 1 → rd_valid never pulses, busy=0.

Source files
------------

// File: rtl/global_bram_port_arbiter.sv
// Read-priority arbiter sharing one global BRAM port between the fused-buffer loader (read)
// and the layer-2 OFM writeback (write), with bounded write starvation and capped write bursts.
module global_bram_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8,
    parameter int WR_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic              busy,
    output logic              err_misalign
);

    // Handshake: a transfer happens in any cycle where req && gnt; requesters hold
    // req and their address/data stable until they see gnt, and gnt never rises without req.

    localparam int WC_W  = $clog2(MAX_WAIT + 1);
    localparam int RUN_W = $clog2(WR_BURST + 1);
    localparam logic [WC_W-1:0]  WAIT_MAX  = WC_W'(MAX_WAIT);
    localparam logic [RUN_W-1:0] BURST_MAX = RUN_W'(WR_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        TURN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              tgt_wr_q, tgt_wr_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [RUN_W-1:0]  wr_run_q, wr_run_d;
    logic [RD_LAT:0]   vld_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              bram_en_q, bram_we_q, err_q;
    logic [ADDR_W-1:0] bram_addr_q;
    logic [DATA_W-1:0] bram_wdata_q;
    logic              force_wr;

    assign force_wr = wr_req && (wait_cnt_q >= WAIT_MAX);

    always_comb begin
        state_d  = state_q;
        tgt_wr_d = tgt_wr_q;
        rd_gnt   = 1'b0;
        wr_gnt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    rd_gnt  = 1'b1;
                    state_d = RD;
                end else if (wr_req) begin
                    wr_gnt  = 1'b1;
                    state_d = WR;
                end
            end
            RD: begin
                if (rd_req && !force_wr) begin
                    rd_gnt = 1'b1;
                end else if (wr_req) begin
                    state_d  = TURN;
                    tgt_wr_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WR: begin
                if (wr_req && (!rd_req || wr_run_q < BURST_MAX)) begin
                    wr_gnt = 1'b1;
                end else if (rd_req) begin
                    state_d  = TURN;
                    tgt_wr_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                // Bubble cycle on a direction change; the target re-evaluates its own rules next.
                state_d = tgt_wr_q ? WR : RD;
            end
        endcase
        if (reset) begin
            rd_gnt = 1'b0;
            wr_gnt = 1'b0;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (wr_gnt || !wr_req) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_comb begin
        wr_run_d = wr_run_q;
        if (state_d != WR) begin
            wr_run_d = '0;
        end else if (state_q == WR && wr_gnt && wr_run_q < BURST_MAX) begin
            wr_run_d = wr_run_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            tgt_wr_q     <= 1'b0;
            wait_cnt_q   <= '0;
            wr_run_q     <= '0;
            vld_q        <= '0;
            rd_data_q    <= '0;
            bram_en_q    <= 1'b0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_wdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_wr_q   <= tgt_wr_d;
            wait_cnt_q <= wait_cnt_d;
            wr_run_q   <= wr_run_d;
            vld_q      <= {vld_q[RD_LAT-1:0], rd_gnt};
            if (vld_q[RD_LAT]) begin
                rd_data_q <= bram_rdata;
            end
            bram_en_q <= rd_gnt || wr_gnt;
            bram_we_q <= wr_gnt;
            if (rd_gnt) begin
                bram_addr_q <= rd_addr;
            end else if (wr_gnt) begin
                bram_addr_q  <= wr_addr;
                bram_wdata_q <= wr_data;
            end
            if ((rd_gnt && rd_addr[1:0] != 2'b00) || (wr_gnt && wr_addr[1:0] != 2'b00)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rd_valid     = vld_q[RD_LAT];
    assign rd_data      = vld_q[RD_LAT] ? bram_rdata : rd_data_q;
    assign bram_en      = bram_en_q;
    assign bram_we      = bram_we_q;
    assign bram_addr    = bram_addr_q;
    assign bram_wdata   = bram_wdata_q;
    assign err_misalign = err_q;
    assign busy         = (state_q != IDLE) || (|vld_q);

endmodule

// File: tb/tb_global_bram_port_arbiter.sv
// Directed bench for global_bram_port_arbiter with a one-cycle-latency BRAM read model.
module tb_global_bram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_gnt;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_gnt;
    logic        bram_en;
    logic        bram_we;
    logic [31:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [31:0] bram_rdata = 32'h0;
    logic        busy;
    logic        err_misalign;

    int n_vec  = 0;
    int n_miss = 0;

    global_bram_port_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_gnt      (rd_gnt),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_gnt      (wr_gnt),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_wdata  (bram_wdata),
        .bram_rdata  (bram_rdata),
        .busy        (busy),
        .err_misalign(err_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // BRAM model: registered read, data appears one cycle after the enabled address cycle.
    always @(posedge clk) begin
        if (bram_en && !bram_we) bram_rdata <= mem_val(bram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_gnt"}, {31'b0, rd_gnt}, 32'h0);
        chk({tag, "_wr_gnt"}, {31'b0, wr_gnt}, 32'h0);
        chk({tag, "_rd_valid"}, {31'b0, rd_valid}, 32'h0);
        chk({tag, "_rd_data"}, rd_data, 32'h0);
        chk({tag, "_bram_en"}, {31'b0, bram_en}, 32'h0);
        chk({tag, "_bram_we"}, {31'b0, bram_we}, 32'h0);
        chk({tag, "_bram_addr"}, bram_addr, 32'h0);
        chk({tag, "_bram_wdata"}, bram_wdata, 32'h0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
        chk({tag, "_err"}, {31'b0, err_misalign}, 32'h0);
    endtask

    initial begin
        reset   = 1'b1;
        rd_req  = 1'b0;
        rd_addr = 32'h0;
        wr_req  = 1'b0;
        wr_addr = 32'h0;
        wr_data = 32'h0;
        next_cycle();
        next_cycle();
        #4;
        chk_all_zero("por");

        // Idle after release
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c != 0) next_cycle();
            #4;
            chk($sformatf("idle_en_c%0d", c), {31'b0, bram_en}, 32'h0);
            chk($sformatf("idle_busy_c%0d", c), {31'b0, busy}, 32'h0);
        end

        // Read-only stream 0x100, 0x104, 0x108
        next_cycle();
        rd_req = 1'b1; rd_addr = 32'h100;
        #4;
        chk("rd_c0_gnt", {31'b0, rd_gnt}, 32'h1);
        chk("rd_c0_wgnt", {31'b0, wr_gnt}, 32'h0);
        next_cycle();
        rd_addr = 32'h104;
        #4;
        chk("rd_c1_gnt", {31'b0, rd_gnt}, 32'h1);
        chk("rd_c1_en", {31'b0, bram_en}, 32'h1);
        chk("rd_c1_we", {31'b0, bram_we}, 32'h0);
        chk("rd_c1_addr", bram_addr, 32'h100);
        chk("rd_c1_valid", {31'b0, rd_valid}, 32'h0);
        next_cycle();
        rd_addr = 32'h108;
        #4;
        chk("rd_c2_gnt", {31'b0, rd_gnt}, 32'h1);
        chk("rd_c2_addr", bram_addr, 32'h104);
        chk("rd_c2_valid", {31'b0, rd_valid}, 32'h1);
        chk("rd_c2_data", rd_data, mem_val(32'h100));
        next_cycle();
        rd_req = 1'b0;
        #4;
        chk("rd_c3_gnt", {31'b0, rd_gnt}, 32'h0);
        chk("rd_c3_en", {31'b0, bram_en}, 32'h1);
        chk("rd_c3_addr", bram_addr, 32'h108);
        chk("rd_c3_valid", {31'b0, rd_valid}, 32'h1);
        chk("rd_c3_data", rd_data, mem_val(32'h104));
        next_cycle();
        #4;
        chk("rd_c4_en", {31'b0, bram_en}, 32'h0);
        chk("rd_c4_valid", {31'b0, rd_valid}, 32'h1);
        chk("rd_c4_data", rd_data, mem_val(32'h108));
        next_cycle();
        #4;
        chk("rd_c5_valid", {31'b0, rd_valid}, 32'h0);
        chk("rd_c5_hold", rd_data, mem_val(32'h108));
        chk("rd_c5_busy", {31'b0, busy}, 32'h0);

        // Write-only: 0x40 <- 0xDEADBEEF
        next_cycle();
        wr_req = 1'b1; wr_addr = 32'h40; wr_data = 32'hDEADBEEF;
        #4;
        chk("wr_c0_gnt", {31'b0, wr_gnt}, 32'h1);
        chk("wr_c0_rgnt", {31'b0, rd_gnt}, 32'h0);
        next_cycle();
        wr_req = 1'b0;
        #4;
        chk("wr_c1_en", {31'b0, bram_en}, 32'h1);
        chk("wr_c1_we", {31'b0, bram_we}, 32'h1);
        chk("wr_c1_addr", bram_addr, 32'h40);
        chk("wr_c1_wdata", bram_wdata, 32'hDEADBEEF);
        chk("wr_c1_valid", {31'b0, rd_valid}, 32'h0);
        for (int c = 2; c < 4; c++) begin
            next_cycle();
            #4;
            chk($sformatf("wr_c%0d_en", c), {31'b0, bram_en}, 32'h0);
            chk($sformatf("wr_c%0d_valid", c), {31'b0, rd_valid}, 32'h0);
        end

        // Starvation bound and burst cap with both requests held
        next_cycle();
        rd_req = 1'b1; rd_addr = 32'h200;
        wr_req = 1'b1; wr_addr = 32'h300; wr_data = 32'h1234_5678;
        for (int c = 0; c <= 16; c++) begin
            if (c != 0) next_cycle();
            #4;
            chk($sformatf("starve_rd_c%0d", c), {31'b0, rd_gnt}, {31'b0, (c <= 7) || (c == 16)});
            chk($sformatf("starve_wr_c%0d", c), {31'b0, wr_gnt}, {31'b0, (c >= 10) && (c <= 13)});
            if (c == 9) chk("starve_c9_en", {31'b0, bram_en}, 32'h0);
            if (c == 11) begin
                chk("starve_c11_we", {31'b0, bram_we}, 32'h1);
                chk("starve_c11_addr", bram_addr, 32'h300);
            end
            if (c == 15) chk("starve_c15_en", {31'b0, bram_en}, 32'h0);
        end
        next_cycle();
        rd_req = 1'b0; wr_req = 1'b0;
        for (int c = 0; c < 4; c++) next_cycle();
        #4;
        chk("starve_drain_busy", {31'b0, busy}, 32'h0);

        // Misaligned read then aligned write; flag is sticky
        next_cycle();
        rd_req = 1'b1; rd_addr = 32'h102;
        #4;
        chk("mis_c0_gnt", {31'b0, rd_gnt}, 32'h1);
        chk("mis_c0_err", {31'b0, err_misalign}, 32'h0);
        next_cycle();
        rd_req = 1'b0;
        #4;
        chk("mis_c1_addr", bram_addr, 32'h102);
        chk("mis_c1_err", {31'b0, err_misalign}, 32'h1);
        next_cycle();
        wr_req = 1'b1; wr_addr = 32'h44; wr_data = 32'h55;
        #4;
        chk("mis_c2_wgnt", {31'b0, wr_gnt}, 32'h1);
        next_cycle();
        #4;
        chk("mis_c3_err", {31'b0, err_misalign}, 32'h1);
        chk("mis_c3_we", {31'b0, bram_we}, 32'h1);

        // Asynchronous reset in the middle of a write stream
        #1;
        reset = 1'b1;
        #1;
        chk_all_zero("async_rst");
        wr_req = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c != 0) next_cycle();
            #4;
            chk($sformatf("post_rst_en_c%0d", c), {31'b0, bram_en}, 32'h0);
        end

        // Reset while a read is in flight: no rd_valid afterwards
        next_cycle();
        rd_req = 1'b1; rd_addr = 32'h10;
        #4;
        chk("fl_c0_gnt", {31'b0, rd_gnt}, 32'h1);
        next_cycle();
        rd_req = 1'b0;
        reset  = 1'b1;
        #1;
        chk("fl_rst_valid", {31'b0, rd_valid}, 32'h0);
        chk("fl_rst_busy", {31'b0, busy}, 32'h0);
        chk("fl_rst_en", {31'b0, bram_en}, 32'h0);
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c != 0) next_cycle();
            #4;
            chk($sformatf("fl_valid_c%0d", c), {31'b0, rd_valid}, 32'h0);
            chk($sformatf("fl_busy_c%0d", c), {31'b0, busy}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
